aibcr3_signal_filt: RTL and testbench

synchronizer plus glitch filter directly downstream of the AIB signal buffer. Brings the buffered asynchronous pad-side signal into the core clock domain and rejects short pulses.

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop count; legal range 2..4.
REQ-002 Parameter FILT_LEN, default 4: consecutive synchronized cycles required before the output follows; legal range 1..255.
REQ-003 Parameter RST_VAL, default 1'b0: reset value of the synchronizer chain and sig_out.
REQ-004 Port clk, input, 1: the only clock; all flops are rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port sig_in, input, 1: asynchronous buffered signal from the signal buffer.
REQ-007 Port glitch_clr, input, 1: synchronous clear of glitch_cnt.
REQ-008 Port vcc, input, 1: supply pin; no logic function.
REQ-009 Port vssl, input, 1: supply pin; no logic function.
REQ-010 Port sig_out, output, 1: filtered, synchronized signal.
REQ-011 Port rise_pls, output, 1: single-cycle pulse when sig_out rises.
REQ-012 Port fall_pls, output, 1: single-cycle pulse when sig_out falls.
REQ-013 Port glitch_cnt, output, 8: saturating count of rejected glitches.

Function
REQ-014 sig_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized value s.
REQ-015 An 8-bit counter cnt SHALL be cleared in any cycle where s equals sig_out.
REQ-016 In a cycle where s differs from sig_out and cnt is below FILT_LEN-1, cnt SHALL increment.
REQ-017 In a cycle where s differs from sig_out and cnt equals FILT_LEN-1, sig_out SHALL take the value of s and cnt SHALL clear, both on that edge.
REQ-018 Latency: sig_in stable before edge 1 SHALL appear on sig_out after edge SYNC_STAGES+FILT_LEN.
REQ-019 Any excursion of s shorter than FILT_LEN cycles SHALL leave sig_out unchanged.
REQ-020 A glitch SHALL count as rejected in a cycle where cnt is nonzero and s equals sig_out; that event SHALL increment glitch_cnt.
REQ-021 glitch_cnt SHALL saturate at 255 and never wrap.
REQ-022 glitch_clr SHALL clear glitch_cnt on the next edge; when glitch_clr and a rejection coincide, the clear wins and glitch_cnt becomes 0.
REQ-023 With FILT_LEN=1, sig_out SHALL follow s with one cycle of delay and glitch_cnt SHALL never increment.
REQ-024 rise_pls SHALL be a registered pulse, high in exactly the cycle after the edge where sig_out changes 0->1.
REQ-025 fall_pls SHALL follow the same rule as rise_pls for a 1->0 change of sig_out.
REQ-026 rise_pls and fall_pls SHALL never be high together.

Reset
REQ-027 While reset is high at a clock edge, all of the following SHALL hold after that edge:
- synchronizer chain = RST_VAL
- sig_out = RST_VAL
- cnt = 0
- glitch_cnt = 0
- rise_pls = 0
- fall_pls = 0
REQ-028 Reset asserted mid-count SHALL abort filtering with no sig_out change, no pulse and no glitch count.
REQ-029 In the first cycle after reset, sig_out SHALL NOT emit rise_pls or fall_pls.

Configuration
REQ-030 Macro AIBCR3_SIGNAL_FILT_EDGE_EN:
- defined: rise_pls and fall_pls SHALL behave per REQ-024 to REQ-026.
- undefined: the ports SHALL remain present, tied to 0, with no edge-detect flops.

Verification (SYNC_STAGES=2, FILT_LEN=4, RST_VAL=0)
REQ-031 sig_in 0->1 held steady -> sig_out=1 after edge 6; rise_pls high for one cycle after that edge; glitch_cnt=0.
REQ-032 sig_in high for 3 cycles then low -> sig_out stays 0; glitch_cnt=1; no pulses.
REQ-033 300 three-cycle glitches -> glitch_cnt=255; assert glitch_clr coincident with a rejection -> glitch_cnt=0.
REQ-034 reset asserted when cnt=2 during a 0->1 transition -> sig_out=0, cnt=0, no pulse; after release, sig_out=1 after edge 6.
REQ-035 sig_in 1->0 after sig_out=1 -> sig_out=0 after edge 6; fall_pls high for one cycle.
REQ-036 Macro undefined, run REQ-031 -> rise_pls and fall_pls constant 0; sig_out timing identical.

---
 rtl/aibcr3_signal_filt.sv | 111 +++++++++++
 tb/tb_aibcr3_signal_filt.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3_signal_filt.sv
// Synchronizer plus glitch filter for the buffered AIB pad signal.
// Define AIBCR3_SIGNAL_FILT_EDGE_EN to build the rise/fall pulse flops; otherwise those outputs are tied low.
module aibcr3_signal_filt #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sig_in,
    input  logic       glitch_clr,
    input  logic       vcc,
    input  logic       vssl,
    output logic       sig_out,
    output logic       rise_pls,
    output logic       fall_pls,
    output logic [7:0] glitch_cnt
);

    localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    logic [7:0]             cnt_reg;
    logic [7:0]             cnt_next;
    logic                   sig_out_reg;
    logic                   sig_out_next;
    logic [7:0]             glitch_cnt_reg;
    logic [7:0]             glitch_cnt_next;
    logic                   update;
    logic                   reject;
    logic                   unused_supply;

    // Supply pins carry no logic; fold them into a sink so they stay connected.
    assign unused_supply = &{1'b0, vcc, vssl};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        update          = 1'b0;
        reject          = 1'b0;
        cnt_next        = cnt_reg;
        sig_out_next    = sig_out_reg;
        glitch_cnt_next = glitch_cnt_reg;

        // A partially counted excursion that collapses back to sig_out is a rejected glitch.
        if (s == sig_out_reg) begin
            cnt_next = 8'd0;
            reject   = (cnt_reg != 8'd0);
        end else if (cnt_reg >= CNT_LAST) begin
            update       = 1'b1;
            sig_out_next = s;
            cnt_next     = 8'd0;
        end else begin
            cnt_next = cnt_reg + 8'd1;
        end

        if (glitch_clr) begin
            glitch_cnt_next = 8'd0;
        end else if (reject && (glitch_cnt_reg != 8'hFF)) begin
            glitch_cnt_next = glitch_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= 8'd0;
            sig_out_reg    <= RST_VAL;
            glitch_cnt_reg <= 8'd0;
        end else begin
            cnt_reg        <= cnt_next;
            sig_out_reg    <= sig_out_next;
            glitch_cnt_reg <= glitch_cnt_next;
        end
    end

    assign sig_out    = sig_out_reg;
    assign glitch_cnt = glitch_cnt_reg;

`ifdef AIBCR3_SIGNAL_FILT_EDGE_EN
    logic rise_pls_reg;
    logic fall_pls_reg;

    // Pulses are registered on the same edge that updates sig_out, so they are
    // high for exactly the cycle following that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_pls_reg <= 1'b0;
            fall_pls_reg <= 1'b0;
        end else begin
            rise_pls_reg <= update & s;
            fall_pls_reg <= update & ~s;
        end
    end

    assign rise_pls = rise_pls_reg;
    assign fall_pls = fall_pls_reg;
`else
    assign rise_pls = 1'b0;
    assign fall_pls = 1'b0;
`endif

endmodule

// File: tb/tb_aibcr3_signal_filt.sv
// Self-checking bench for aibcr3_signal_filt: directed scenarios plus random sig_in
// checked against a window-based reference model.
module tb_aibcr3_signal_filt;

    localparam int   SYNC_STAGES = 2;
    localparam int   FILT_LEN    = 4;
    localparam logic RST_VAL     = 1'b0;
`ifdef AIBCR3_SIGNAL_FILT_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sig_in;
    logic       glitch_clr;
    logic       vcc;
    logic       vssl;
    logic       sig_out;
    logic       rise_pls;
    logic       fall_pls;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: sync pipeline, recent s window, expected outputs.
    logic m_sync[$];
    logic m_sq[$];
    logic m_out;
    logic m_rise;
    logic m_fall;
    logic m_reject;
    int   m_glitch;

    always #5 clk = ~clk;

    aibcr3_signal_filt #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN),
        .RST_VAL    (RST_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .glitch_clr(glitch_clr),
        .vcc       (vcc),
        .vssl      (vssl),
        .sig_out   (sig_out),
        .rise_pls  (rise_pls),
        .fall_pls  (fall_pls),
        .glitch_cnt(glitch_cnt)
    );

    // Advance one clock and the model alongside it; leaves time at the falling edge.
    // sig_out follows s once the last FILT_LEN values of s all differ from it.
    task automatic step();
        logic in_v, rst_v, clr_v, s_cur, all_diff;
        in_v  = sig_in;
        rst_v = reset;
        clr_v = glitch_clr;
        @(posedge clk);
        m_reject = 1'b0;
        if (rst_v) begin
            m_sync = {};
            repeat (SYNC_STAGES) m_sync.push_back(RST_VAL);
            m_sq     = {};
            m_out    = RST_VAL;
            m_glitch = 0;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
        end else begin
            s_cur = m_sync[SYNC_STAGES-1];
            m_sync.push_front(in_v);
            void'(m_sync.pop_back());
            m_sq.push_back(s_cur);
            if (m_sq.size() > FILT_LEN) void'(m_sq.pop_front());
            all_diff = (m_sq.size() == FILT_LEN);
            foreach (m_sq[i]) if (m_sq[i] == m_out) all_diff = 1'b0;
            m_reject = (s_cur == m_out) && (m_sq.size() >= 2) && (m_sq[m_sq.size()-2] != m_out);
            m_rise   = EDGE_EN && all_diff && s_cur;
            m_fall   = EDGE_EN && all_diff && !s_cur;
            if (all_diff) m_out = s_cur;
            if (clr_v) m_glitch = 0;
            else if (m_reject && m_glitch < 255) m_glitch++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (sig_out !== RST_VAL) begin n_fail++; $display("FAIL reset_sig_out: got %b want %b", sig_out, RST_VAL); end
        n_checks++;
        if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_glitch_cnt: got %0d want 0", glitch_cnt); end
        n_checks++;
        if ({rise_pls, fall_pls} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", rise_pls, fall_pls); end
        reset = 1'b0;
        step();
        n_checks++;
        if ({rise_pls, fall_pls, sig_out} !== {2'b00, RST_VAL}) begin
            n_fail++; $display("FAIL post_reset: got rise=%b fall=%b out=%b want 0 0 %b", rise_pls, fall_pls, sig_out, RST_VAL);
        end
        repeat (4) step();
        $display("test_reset: out=%b glitch=%0d", sig_out, glitch_cnt);
    endtask

    task automatic test_transition(input logic to_val, input string name);
        logic exp_out;
        sig_in = to_val;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_out = (k >= SYNC_STAGES + FILT_LEN) ? to_val : !to_val;
            n_checks++;
            if (sig_out !== exp_out) begin n_fail++; $display("FAIL %s_out edge %0d: got %b want %b", name, k, sig_out, exp_out); end
            n_checks++;
            if (rise_pls !== (EDGE_EN && to_val && k == 6)) begin
                n_fail++; $display("FAIL %s_rise edge %0d: got %b want %b", name, k, rise_pls, EDGE_EN && to_val && k == 6);
            end
            n_checks++;
            if (fall_pls !== (EDGE_EN && !to_val && k == 6)) begin
                n_fail++; $display("FAIL %s_fall edge %0d: got %b want %b", name, k, fall_pls, EDGE_EN && !to_val && k == 6);
            end
            n_checks++;
            if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL %s_glitch edge %0d: got %0d want 0", name, k, glitch_cnt); end
        end
        $display("test_%s: out=%b", name, sig_out);
    endtask

    task automatic test_glitch();
        sig_in = 1'b1;
        repeat (3) step();
        sig_in = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            n_checks++;
            if ({sig_out, rise_pls, fall_pls} !== 3'b000) begin
                n_fail++; $display("FAIL glitch_quiet cycle %0d: got out=%b rise=%b fall=%b want 000", k, sig_out, rise_pls, fall_pls);
            end
        end
        n_checks++;
        if (glitch_cnt !== 8'd1) begin n_fail++; $display("FAIL glitch_count: got %0d want 1", glitch_cnt); end
        $display("test_glitch: glitch_cnt=%0d", glitch_cnt);
    endtask

    task automatic test_saturate();
        for (int g = 0; g < 300; g++) begin
            sig_in = 1'b1;
            repeat (3) step();
            sig_in = 1'b0;
            repeat (3) step();
        end
        n_checks++;
        if (glitch_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate: got %0d want 255", glitch_cnt); end
        n_checks++;
        if (sig_out !== 1'b0) begin n_fail++; $display("FAIL saturate_out: got %b want 0", sig_out); end
        // One more glitch; its rejection lands on the sixth edge, where glitch_clr is also high.
        sig_in = 1'b1;
        repeat (3) step();
        sig_in = 1'b0;
        repeat (2) step();
        n_checks++;
        if (glitch_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate_hold: got %0d want 255", glitch_cnt); end
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;
        n_checks++;
        if (glitch_cnt !== 8'd0 || !m_reject) begin
            n_fail++; $display("FAIL clr_vs_reject: got %0d want 0 (model reject=%b)", glitch_cnt, m_reject);
        end
        $display("test_saturate: glitch_cnt=%0d", glitch_cnt);
    endtask

    task automatic test_reset_mid();
        sig_in = 1'b0;
        repeat (6) step();
        sig_in = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({sig_out, rise_pls, fall_pls, glitch_cnt} !== 11'd0) begin
            n_fail++; $display("FAIL reset_mid: got out=%b rise=%b fall=%b glitch=%0d want all 0", sig_out, rise_pls, fall_pls, glitch_cnt);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (sig_out !== (k >= 6)) begin n_fail++; $display("FAIL reset_mid_out edge %0d: got %b want %b", k, sig_out, k >= 6); end
            n_checks++;
            if ({rise_pls, fall_pls} !== {EDGE_EN && k == 6, 1'b0}) begin
                n_fail++; $display("FAIL reset_mid_pulse edge %0d: got %b%b want %b0", k, rise_pls, fall_pls, EDGE_EN && k == 6);
            end
            n_checks++;
            if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_mid_glitch edge %0d: got %0d want 0", k, glitch_cnt); end
        end
        $display("test_reset_mid: out=%b", sig_out);
    endtask

    task automatic test_random();
        int run;
        for (int burst = 0; burst < 600; burst++) begin
            sig_in = 1'($urandom_range(0, 1));
            run    = $urandom_range(1, 7);
            for (int c = 0; c < run; c++) begin
                glitch_clr = ($urandom_range(0, 39) == 0);
                reset      = ($urandom_range(0, 499) == 0);
                step();
                n_checks++;
                if (sig_out !== m_out) begin n_fail++; $display("FAIL rand_out burst %0d: got %b want %b", burst, sig_out, m_out); end
                n_checks++;
                if (glitch_cnt !== 8'(m_glitch)) begin n_fail++; $display("FAIL rand_glitch burst %0d: got %0d want %0d", burst, glitch_cnt, m_glitch); end
                n_checks++;
                if (rise_pls !== m_rise) begin n_fail++; $display("FAIL rand_rise burst %0d: got %b want %b", burst, rise_pls, m_rise); end
                n_checks++;
                if (fall_pls !== m_fall) begin n_fail++; $display("FAIL rand_fall burst %0d: got %b want %b", burst, fall_pls, m_fall); end
                n_checks++;
                if (rise_pls === 1'b1 && fall_pls === 1'b1) begin n_fail++; $display("FAIL rand_both_pulses burst %0d: got 11 want not both", burst); end
            end
        end
        glitch_clr = 1'b0;
        reset      = 1'b0;
        $display("test_random: final out=%b glitch=%0d", sig_out, glitch_cnt);
    endtask

    initial begin
        reset      = 1'b1;
        sig_in     = 1'b0;
        glitch_clr = 1'b0;
        vcc        = 1'b1;
        vssl       = 1'b0;
        @(negedge clk);
        test_reset();
        test_transition(1'b1, "rise");
        test_transition(1'b0, "fall");
        test_glitch();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
